// File: rtl/oric_ram_arbiter_if.sv
// Oric main-RAM arbiter bus bundle: fill control, CPU port, HPS ioctl loader
// channel, RAM port and status. The arbiter uses the slave modport; the
// surrounding system (core, hps_io, RAM array) uses the master modport.
interface oric_ram_arbiter_if;
    logic        clr_start;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_d;
    logic        cpu_cs;
    logic        cpu_we;
    logic [7:0]  cpu_q;
    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        ioctl_wr;
    logic        ioctl_wait;
    logic [15:0] mem_addr;
    logic [7:0]  mem_din;
    logic        mem_we;
    logic [7:0]  mem_q;
    logic        core_reset;
    logic        load_busy;
    logic        load_ovf;

    modport master (
        output clr_start, cpu_addr, cpu_d, cpu_cs, cpu_we,
        output ioctl_download, ioctl_index, ioctl_addr, ioctl_dout, ioctl_wr,
        output mem_q,
        input  cpu_q, ioctl_wait, mem_addr, mem_din, mem_we,
        input  core_reset, load_busy, load_ovf
    );

    modport slave (
        input  clr_start, cpu_addr, cpu_d, cpu_cs, cpu_we,
        input  ioctl_download, ioctl_index, ioctl_addr, ioctl_dout, ioctl_wr,
        input  mem_q,
        output cpu_q, ioctl_wait, mem_addr, mem_din, mem_we,
        output core_reset, load_busy, load_ovf
    );
endinterface

// File: rtl/oric_ram_arbiter.sv
// Oric 64 KB main RAM sequencer: fills RAM with FILL_VAL after reset or
// clr_start while holding the core in reset, then shares the single RAM port
// between the CPU (highest priority) and a byte loader fed from hps_io.
// Define ORIC_RAM_LOADER_EN to build the loader FIFO; without it the ioctl
// channel is ignored and the loader status outputs are tied low.
module oric_ram_arbiter #(
    parameter logic [7:0]  FILL_VAL   = 8'hFF,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [7:0]  LOAD_INDEX = 8'd1,
    parameter logic [15:0] LOAD_BASE  = 16'h0500
) (
    input logic               clk_sys,
    input logic               reset,
    oric_ram_arbiter_if.slave bus
);
    typedef enum logic {CLEAR, RUN} state_t;

    state_t      state;
    logic [16:0] fa;
    logic        core_rst;
    logic        pop;
    logic        fifo_empty;
    logic [15:0] head_addr;
    logic [7:0]  head_data;
    logic        unused_bits;

    assign bus.cpu_q      = bus.mem_q;
    assign bus.core_reset = core_rst;

    // Fill sequencer: walk every address once, then hand the port to RUN
    always_ff @(posedge clk_sys) begin
        if (reset || bus.clr_start) begin
            state    <= CLEAR;
            fa       <= '0;
            core_rst <= 1'b1;
        end else if (state == CLEAR) begin
            fa <= fa + 17'd1;
            if (fa[15:0] == 16'hFFFF) begin
                state    <= RUN;
                core_rst <= 1'b0;
            end
        end
    end

    // RAM port mux: fill in CLEAR, otherwise CPU first, then loader FIFO
    always_comb begin
        bus.mem_addr = bus.cpu_addr;
        bus.mem_din  = bus.cpu_d;
        bus.mem_we   = 1'b0;
        pop          = 1'b0;
        if (state == CLEAR) begin
            bus.mem_addr = fa[15:0];
            bus.mem_din  = FILL_VAL;
            bus.mem_we   = 1'b1;
        end else if (!bus.clr_start) begin
            if (bus.cpu_cs) begin
                bus.mem_we = bus.cpu_we;
            end else if (!fifo_empty) begin
                pop          = 1'b1;
                bus.mem_addr = head_addr;
                bus.mem_din  = head_data;
                bus.mem_we   = 1'b1;
            end
        end
    end

`ifdef ORIC_RAM_LOADER_EN
    localparam int               PTR_W   = $clog2(FIFO_DEPTH);
    localparam int               WAIT_I  = FIFO_DEPTH - 1;
    localparam logic [PTR_W:0]   DEPTH_C = FIFO_DEPTH[PTR_W:0];
    localparam logic [PTR_W:0]   WAIT_C  = WAIT_I[PTR_W:0];

    logic [15:0]      fifo_addr [FIFO_DEPTH];
    logic [7:0]       fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             push_req;
    logic             push_ok;
    logic [15:0]      push_addr;
    logic             ovf;

    assign push_req   = bus.ioctl_wr & bus.ioctl_download & (bus.ioctl_index == LOAD_INDEX);
    assign push_addr  = LOAD_BASE + bus.ioctl_addr[15:0];
    assign push_ok    = push_req && ((count < DEPTH_C) || pop);
    assign fifo_empty = (count == '0);
    assign head_addr  = fifo_addr[rd_ptr];
    assign head_data  = fifo_data[rd_ptr];

    assign bus.ioctl_wait = (count >= WAIT_C);
    assign bus.load_busy  = bus.ioctl_download | ~fifo_empty;
    assign bus.load_ovf   = ovf;
    assign unused_bits    = ^{fa[16], bus.ioctl_addr[24:16]};

    // Loader FIFO: held empty during fill; a pop frees room for a same-cycle push
    always_ff @(posedge clk_sys) begin
        if (reset || bus.clr_start || state == CLEAR) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                fifo_addr[wr_ptr] <= push_addr;
                fifo_data[wr_ptr] <= bus.ioctl_dout;
                wr_ptr            <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_ok && !pop) begin
                count <= count + 1'b1;
            end else if (!push_ok && pop) begin
                count <= count - 1'b1;
            end
        end
    end

    // Sticky overflow: a RUN-time byte that found the FIFO full; only reset clears it
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            ovf <= 1'b0;
        end else if (state == RUN && !bus.clr_start && push_req && !push_ok) begin
            ovf <= 1'b1;
        end
    end
`else
    assign fifo_empty     = 1'b1;
    assign head_addr      = '0;
    assign head_data      = '0;
    assign bus.ioctl_wait = 1'b0;
    assign bus.load_busy  = 1'b0;
    assign bus.load_ovf   = 1'b0;
    assign unused_bits    = ^{fa[16], pop, bus.ioctl_download, bus.ioctl_index,
                              bus.ioctl_addr, bus.ioctl_dout, bus.ioctl_wr,
                              LOAD_INDEX, LOAD_BASE, FIFO_DEPTH[0]};
`endif
endmodule

// File: tb/tb_oric_ram_arbiter.sv
// Directed bench for oric_ram_arbiter with a behavioural 64 KB RAM that has
// registered read data. Expectations follow the build: with
// ORIC_RAM_LOADER_EN defined the loader bytes land in RAM, otherwise they
// must never reach it.
module tb_oric_ram_arbiter;
`ifdef ORIC_RAM_LOADER_EN
    localparam bit LOADER = 1'b1;
`else
    localparam bit LOADER = 1'b0;
`endif

    logic clk_sys = 1'b0;
    logic reset   = 1'b1;
    int   compared   = 0;
    int   mismatched = 0;
    int   loader_writes;

    logic [7:0] ram [65536];
    logic [7:0] bp_data [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

    oric_ram_arbiter_if bus ();

    oric_ram_arbiter dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .bus     (bus)
    );

    always #5 clk_sys = ~clk_sys;

    // RAM model: write strobe plus registered read; also counts RUN writes not owned by the CPU
    always @(posedge clk_sys) begin
        if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_din;
        bus.mem_q <= ram[bus.mem_addr];
        if (reset) loader_writes <= 0;
        else if (bus.mem_we && !bus.core_reset && !bus.cpu_cs) loader_writes <= loader_writes + 1;
    end

    // Hard stop in case the flow stalls somewhere unexpected
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic idle_inputs();
        bus.clr_start      = 1'b0;
        bus.cpu_addr       = 16'h0000;
        bus.cpu_d          = 8'h00;
        bus.cpu_cs         = 1'b0;
        bus.cpu_we         = 1'b0;
        bus.ioctl_download = 1'b0;
        bus.ioctl_index    = 8'd0;
        bus.ioctl_addr     = 25'd0;
        bus.ioctl_dout     = 8'h00;
        bus.ioctl_wr       = 1'b0;
    endtask

    task automatic test_reset();
        int n;
        int bad;
        logic [15:0] a1;
        logic [15:0] alast;
        a1 = 16'hxxxx;
        alast = 16'hxxxx;
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
        compared++; if (bus.core_reset !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_core_reset: got %b want 1", bus.core_reset); end
        compared++; if (bus.mem_we !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_mem_we: got %b want 1", bus.mem_we); end
        compared++; if (bus.mem_addr !== 16'h0000) begin mismatched++; $display("[TB] FAIL reset_mem_addr: got %h want 0000", bus.mem_addr); end
        compared++; if (bus.mem_din !== 8'hFF) begin mismatched++; $display("[TB] FAIL reset_mem_din: got %h want ff", bus.mem_din); end
        compared++; if (bus.ioctl_wait !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_ioctl_wait: got %b want 0", bus.ioctl_wait); end
        compared++; if (bus.load_busy !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_load_busy: got %b want 0", bus.load_busy); end
        compared++; if (bus.load_ovf !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_load_ovf: got %b want 0", bus.load_ovf); end
        n = 0;
        while (bus.core_reset === 1'b1 && n < 70000) begin
            if (n == 1) a1 = bus.mem_addr;
            if (n == 65535) alast = bus.mem_addr;
            n++;
            tick();
        end
        compared++; if (n != 65536) begin mismatched++; $display("[TB] FAIL fill_length: got %0d cycles want 65536", n); end
        compared++; if (a1 !== 16'h0001) begin mismatched++; $display("[TB] FAIL fill_addr_1: got %h want 0001", a1); end
        compared++; if (alast !== 16'hFFFF) begin mismatched++; $display("[TB] FAIL fill_addr_last: got %h want ffff", alast); end
        compared++; if (bus.mem_we !== 1'b0) begin mismatched++; $display("[TB] FAIL run_idle_we: got %b want 0", bus.mem_we); end
        bad = 0;
        for (int i = 0; i < 65536; i++) if (ram[i] !== 8'hFF) bad++;
        compared++; if (bad != 0) begin mismatched++; $display("[TB] FAIL fill_contents: %0d locations not ff, want 0", bad); end
    endtask

    task automatic test_cpu_rw();
        tick();
        bus.cpu_cs = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 16'h1234; bus.cpu_d = 8'h5A;
        #1;
        compared++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== 16'h1234 || bus.mem_din !== 8'h5A) begin mismatched++; $display("[TB] FAIL cpu_write: got we=%b addr=%h din=%h want 1/1234/5a", bus.mem_we, bus.mem_addr, bus.mem_din); end
        tick();
        bus.cpu_we = 1'b0;
        #1;
        compared++; if (bus.mem_we !== 1'b0 || bus.mem_addr !== 16'h1234) begin mismatched++; $display("[TB] FAIL cpu_read_req: got we=%b addr=%h want 0/1234", bus.mem_we, bus.mem_addr); end
        tick();
        bus.cpu_cs = 1'b0;
        #1;
        compared++; if (bus.cpu_q !== 8'h5A) begin mismatched++; $display("[TB] FAIL cpu_read_data: got %h want 5a", bus.cpu_q); end
    endtask

    task automatic test_back_pressure();
        logic exp_wait [5];
        logic exp_ovf [5];
        exp_wait = '{1'b0, 1'b0, LOADER, LOADER, LOADER};
        exp_ovf  = '{1'b0, 1'b0, 1'b0, 1'b0, LOADER};
        tick();
        bus.cpu_cs = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h2000;
        bus.ioctl_download = 1'b1; bus.ioctl_index = 8'd1;
        for (int k = 0; k < 5; k++) begin
            bus.ioctl_wr = 1'b1; bus.ioctl_addr = 25'(k); bus.ioctl_dout = bp_data[k];
            tick();
            compared++; if (bus.ioctl_wait !== exp_wait[k]) begin mismatched++; $display("[TB] FAIL bp_wait_%0d: got %b want %b", k, bus.ioctl_wait, exp_wait[k]); end
            compared++; if (bus.load_ovf !== exp_ovf[k]) begin mismatched++; $display("[TB] FAIL bp_ovf_%0d: got %b want %b", k, bus.load_ovf, exp_ovf[k]); end
        end
        bus.ioctl_wr = 1'b0; bus.ioctl_download = 1'b0; bus.cpu_cs = 1'b0;
        #1;
        compared++; if (bus.mem_we !== LOADER) begin mismatched++; $display("[TB] FAIL drain_we: got %b want %b", bus.mem_we, LOADER); end
        compared++; if (bus.mem_addr !== (LOADER ? 16'h0500 : 16'h2000)) begin mismatched++; $display("[TB] FAIL drain_addr: got %h want %h", bus.mem_addr, LOADER ? 16'h0500 : 16'h2000); end
        tick(); tick(); tick();
        compared++; if (bus.load_busy !== LOADER) begin mismatched++; $display("[TB] FAIL drain_busy_3: got %b want %b", bus.load_busy, LOADER); end
        tick();
        compared++; if (bus.load_busy !== 1'b0) begin mismatched++; $display("[TB] FAIL drain_busy_4: got %b want 0", bus.load_busy); end
        compared++; if (bus.ioctl_wait !== 1'b0) begin mismatched++; $display("[TB] FAIL drain_wait: got %b want 0", bus.ioctl_wait); end
        compared++; if (bus.load_ovf !== LOADER) begin mismatched++; $display("[TB] FAIL ovf_sticky: got %b want %b", bus.load_ovf, LOADER); end
        for (int i = 0; i < 4; i++) begin
            compared++; if (ram[16'h0500 + 16'(i)] !== (LOADER ? bp_data[i] : 8'hFF)) begin mismatched++; $display("[TB] FAIL load_ram_%0d: got %h want %h", i, ram[16'h0500 + 16'(i)], LOADER ? bp_data[i] : 8'hFF); end
        end
        compared++; if (ram[16'h0504] !== 8'hFF) begin mismatched++; $display("[TB] FAIL dropped_byte: got %h want ff", ram[16'h0504]); end
    endtask

    task automatic test_wrap_and_index();
        tick();
        bus.ioctl_download = 1'b1; bus.ioctl_index = 8'd1;
        bus.ioctl_addr = 25'h10FB00; bus.ioctl_dout = 8'h3C; bus.ioctl_wr = 1'b1;
        tick();
        bus.ioctl_wr = 1'b0;
        #1;
        compared++; if (bus.mem_we !== LOADER) begin mismatched++; $display("[TB] FAIL wrap_we: got %b want %b", bus.mem_we, LOADER); end
        compared++; if (bus.mem_addr !== (LOADER ? 16'h0000 : 16'h2000)) begin mismatched++; $display("[TB] FAIL wrap_addr: got %h want %h", bus.mem_addr, LOADER ? 16'h0000 : 16'h2000); end
        tick();
        compared++; if (ram[0] !== (LOADER ? 8'h3C : 8'hFF)) begin mismatched++; $display("[TB] FAIL wrap_ram: got %h want %h", ram[0], LOADER ? 8'h3C : 8'hFF); end
        bus.ioctl_index = 8'd0; bus.ioctl_addr = 25'h10; bus.ioctl_dout = 8'h77; bus.ioctl_wr = 1'b1;
        tick();
        bus.ioctl_wr = 1'b0;
        #1;
        compared++; if (bus.mem_we !== 1'b0) begin mismatched++; $display("[TB] FAIL index0_we: got %b want 0", bus.mem_we); end
        compared++; if (bus.load_busy !== LOADER) begin mismatched++; $display("[TB] FAIL index0_busy: got %b want %b", bus.load_busy, LOADER); end
        tick();
        compared++; if (ram[16'h0510] !== 8'hFF) begin mismatched++; $display("[TB] FAIL index0_ram: got %h want ff", ram[16'h0510]); end
        bus.ioctl_download = 1'b0;
        tick();
        compared++; if (loader_writes != (LOADER ? 5 : 0)) begin mismatched++; $display("[TB] FAIL loader_write_count: got %0d want %0d", loader_writes, LOADER ? 5 : 0); end
    endtask

    task automatic test_clr_start();
        int bad_rst;
        int bad_addr;
        tick();
        bus.cpu_cs = 1'b1; bus.cpu_we = 1'b0;
        bus.ioctl_download = 1'b1; bus.ioctl_index = 8'd1; bus.ioctl_wr = 1'b1;
        bus.ioctl_addr = 25'h20; bus.ioctl_dout = 8'hAA;
        tick();
        bus.ioctl_addr = 25'h21; bus.ioctl_dout = 8'hBB;
        tick();
        bus.ioctl_wr = 1'b0; bus.cpu_cs = 1'b0; bus.clr_start = 1'b1;
        #1;
        compared++; if (bus.load_busy !== LOADER) begin mismatched++; $display("[TB] FAIL clr_busy_before: got %b want %b", bus.load_busy, LOADER); end
        compared++; if (bus.mem_we !== 1'b0) begin mismatched++; $display("[TB] FAIL clr_cycle_we: got %b want 0", bus.mem_we); end
        tick();
        bus.clr_start = 1'b0;
        #1;
        compared++; if (bus.core_reset !== 1'b1 || bus.mem_addr !== 16'h0000 || bus.mem_we !== 1'b1 || bus.mem_din !== 8'hFF) begin mismatched++; $display("[TB] FAIL clr_restart: got rst=%b addr=%h we=%b din=%h want 1/0000/1/ff", bus.core_reset, bus.mem_addr, bus.mem_we, bus.mem_din); end
        compared++; if (bus.load_busy !== LOADER) begin mismatched++; $display("[TB] FAIL clr_busy_dl: got %b want %b", bus.load_busy, LOADER); end
        compared++; if (bus.ioctl_wait !== 1'b0) begin mismatched++; $display("[TB] FAIL clr_wait: got %b want 0", bus.ioctl_wait); end
        bus.ioctl_download = 1'b0;
        #1;
        compared++; if (bus.load_busy !== 1'b0) begin mismatched++; $display("[TB] FAIL clr_flushed: got %b want 0", bus.load_busy); end
        bad_rst = 0;
        bad_addr = 0;
        for (int n = 1; n < 1536; n++) begin
            bus.ioctl_download = 1'b1; bus.ioctl_addr = 25'h20; bus.ioctl_dout = 8'hEE;
            bus.ioctl_wr = (n % 2 == 0);
            tick();
            if (bus.core_reset !== 1'b1) bad_rst++;
            if (bus.mem_addr !== 16'(n)) bad_addr++;
        end
        bus.ioctl_wr = 1'b0; bus.ioctl_download = 1'b0;
        #1;
        compared++; if (bad_rst != 0) begin mismatched++; $display("[TB] FAIL clr_hold_reset: %0d cycles released, want 0", bad_rst); end
        compared++; if (bad_addr != 0) begin mismatched++; $display("[TB] FAIL clr_addr_seq: %0d bad addresses, want 0", bad_addr); end
        compared++; if (bus.ioctl_wait !== 1'b0) begin mismatched++; $display("[TB] FAIL clr_fill_wait: got %b want 0", bus.ioctl_wait); end
        compared++; if (ram[16'h0520] !== 8'hFF || ram[16'h0521] !== 8'hFF) begin mismatched++; $display("[TB] FAIL clr_no_load: got %h %h want ff ff", ram[16'h0520], ram[16'h0521]); end
        bus.clr_start = 1'b1;
        tick();
        bus.clr_start = 1'b0;
        #1;
        compared++; if (bus.mem_addr !== 16'h0000 || bus.core_reset !== 1'b1) begin mismatched++; $display("[TB] FAIL clr_repeat: got addr=%h rst=%b want 0000/1", bus.mem_addr, bus.core_reset); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.ioctl_download = 1'b1; bus.ioctl_index = 8'd1; bus.ioctl_wr = 1'b1;
        for (int n = 0; n < 6; n++) tick();
        bus.ioctl_wr = 1'b0;
        #1;
        compared++; if (bus.load_ovf !== 1'b0) begin mismatched++; $display("[TB] FAIL clear_push_ovf: got %b want 0", bus.load_ovf); end
        compared++; if (bus.ioctl_wait !== 1'b0) begin mismatched++; $display("[TB] FAIL clear_push_wait: got %b want 0", bus.ioctl_wait); end
        compared++; if (bus.load_busy !== LOADER) begin mismatched++; $display("[TB] FAIL clear_push_busy: got %b want %b", bus.load_busy, LOADER); end
        bus.ioctl_download = 1'b0;
    endtask

    initial begin
        $display("[TB] oric_ram_arbiter bench, loader build = %0d", LOADER);
        test_reset();
        test_cpu_rw();
        test_back_pressure();
        test_wrap_and_index();
        test_clr_start();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/oric_ram_arbiter.md
# oric_ram_arbiter

Single-port sequencer for the Oric 64 KB main RAM. It owns the power-on/reset fill of RAM and holds the core in reset while the fill runs. Once the fill completes, it shares the RAM port between the CPU core and a byte-stream loader fed from the HPS ioctl channel. It sits between `hps_io`, the `oricatmos` core and the inferred `ram` array in the top-level `emu`.

## Interface
Parameters:
- `FILL_VAL`, default 8'hFF: byte written to every location during fill.
- `FIFO_DEPTH`, default 4: loader FIFO entries; power of two, 2..16.
- `LOAD_INDEX`, default 8'd1: `ioctl_index` value accepted by the loader.
- `LOAD_BASE`, default 16'h0500: RAM address of loader byte 0.

Ports:
- `clk_sys` in 1: system clock; the only clock.
- `reset` in 1: synchronous reset, active-high.
- `clr_start` in 1: level/pulse; (re)starts the RAM fill.
- `cpu_addr` in 16: core RAM address.
- `cpu_d` in 8: core write data.
- `cpu_cs` in 1: core RAM select.
- `cpu_we` in 1: core write enable, qualified by `cpu_cs`.
- `cpu_q` out 8: read data to core; equals `mem_q`.
- `ioctl_download` in 1: loader transfer active.
- `ioctl_index` in 8: transfer index.
- `ioctl_addr` in 25: byte offset within the transfer.
- `ioctl_dout` in 8: byte data.
- `ioctl_wr` in 1: one-cycle byte strobe.
- `ioctl_wait` out 1: back-pressure to `hps_io`.
- `mem_addr` out 16: RAM address.
- `mem_din` out 8: RAM write data.
- `mem_we` out 1: RAM write strobe.
- `mem_q` in 8: RAM registered read data.
- `core_reset` out 1: reset to `oricatmos`.
- `load_busy` out 1: `ioctl_download` active or FIFO not empty.
- `load_ovf` out 1: sticky flag; a byte was dropped.

## Operation
- Two states:
  - CLEAR: fill counter `fa` (17 bits) runs.
  - RUN: normal arbitration.
- `reset` → CLEAR, `fa`=0, FIFO flushed, `load_ovf`=0.
- CLEAR, each cycle:
  - `mem_addr`=`fa[15:0]`, `mem_din`=`FILL_VAL`, `mem_we`=1, `core_reset`=1.
  - CPU and FIFO drain are ignored; FIFO is held flushed and pushes are dropped without setting `load_ovf`.
  - After the write at 16'hFFFF → RUN.
- `clr_start`=1 in any state → CLEAR with `fa`=0 next cycle. A repeat during CLEAR restarts the fill. This outranks all other events.
- RUN: `core_reset`=0. Fixed priority, CPU first:
  - `cpu_cs`=1: `mem_addr`=`cpu_addr`, `mem_din`=`cpu_d`, `mem_we`=`cpu_we`.
  - else FIFO not empty: pop head; `mem_addr`=head addr, `mem_din`=head data, `mem_we`=1.
  - else `mem_we`=0, `mem_addr`=`cpu_addr`.
- Loader push condition: `ioctl_wr & ioctl_download & (ioctl_index==LOAD_INDEX)`. Entry is {(`LOAD_BASE`+`ioctl_addr[15:0]`) mod 2^16, `ioctl_dout`}. Address wraps at 16'hFFFF; `ioctl_addr[24:16]` is ignored.
- Push is accepted if count<`FIFO_DEPTH`, or if a pop happens in the same cycle. Otherwise the byte is dropped and `load_ovf`←1. Only `reset` clears `load_ovf`.
- `ioctl_wait` = (count ≥ `FIFO_DEPTH`-1), giving one cycle of strobe slack.
- Memory outputs (`mem_addr`, `mem_din`, `mem_we`) are combinational from state, FIFO head and CPU inputs. State, counters and FIFO are registered.

## Timing
- Values in the first cycle after reset: `core_reset`=1, `mem_we`=1, `mem_addr`=0, `mem_din`=`FILL_VAL`, `ioctl_wait`=0, `load_busy`=`ioctl_download`, `load_ovf`=0.
- Fill length is exactly 65536 cycles from the cycle after reset or `clr_start`. `core_reset` falls in cycle 65537.
- CPU read latency is 1 cycle: `cpu_q` is valid the cycle after `cpu_cs`. The arbiter adds no delay.
- A FIFO entry pushed in cycle N is poppable in N+1.
- `load_busy` falls the cycle after the last pop, provided `ioctl_download`=0.

## Configuration
- `ORIC_RAM_LOADER_EN` defined: FIFO, loader path, `ioctl_wait`, `load_busy` and `load_ovf` are implemented as above.
- Undefined: no FIFO is instantiated and the ioctl inputs are unused. `ioctl_wait`, `load_busy` and `load_ovf` are tied 0. RUN gives the port to the CPU only.

## Test plan
- Reset, then idle 65540 cycles → `core_reset` high for exactly 65536 cycles; all RAM locations read 8'hFF; `mem_we` low afterwards.
- RUN: CPU writes 8'h5A to 16'h1234, then reads it → `cpu_q`=8'h5A one cycle after the read `cpu_cs`.
- Hold `cpu_cs`=1 and push 4 bytes (index 1, addr 0..3) → `ioctl_wait` high after the 3rd push; 4th accepted; a 5th dropped with `load_ovf`=1. Release `cpu_cs` → RAM 16'h0500..0503 holds the bytes after 4 cycles.
- Push at `ioctl_addr`=16'hFB00 → write lands at 16'h0000 (wrap). Push with `ioctl_index`=0 → no write.
- `clr_start` during a loader burst with the FIFO non-empty → FIFO flushed, `load_busy` follows `ioctl_download`, a full 65536-cycle fill runs, and no loader byte is written.
- Build without `ORIC_RAM_LOADER_EN` and drive ioctl strobes → no RAM writes outside CLEAR; `ioctl_wait`=0.
